// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: valid/ready note events, fixed-latency table scan, registered read port.
// Optional build macro VOICE_STEAL_EN: when defined, a note-on into a full table overwrites a round-robin victim slot.
module voice_allocator #(
   parameter int VOICES = 64,
   parameter int AW     = 6
) (
   input  logic          i_clk,
   input  logic          i_res,
   input  logic          i_ev_valid,
   output logic          o_ev_ready,
   input  logic          i_ev_on,
   input  logic [3:0]    i_ev_ch,
   input  logic [6:0]    i_ev_note,
   input  logic [6:0]    i_ev_vel,
   input  logic [AW-1:0] i_rdaddr,
   output logic [15:0]   o_rddata,
   output logic [AW:0]   o_active_cnt,
   output logic          o_drop
);

   localparam logic [AW-1:0] LAST    = AW'(VOICES - 1);
   localparam logic [AW:0]   CNT_MAX = (AW + 1)'(VOICES);

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_COMMIT} state_t;

   state_t        state;
   logic [AW-1:0] idx;
   logic          ev_on;
   logic [3:0]    ev_ch;
   logic [6:0]    ev_note;
   logic [6:0]    ev_vel;
   logic          match_f;
   logic          free_f;
   logic [AW-1:0] match_idx;
   logic [AW-1:0] free_idx;
   logic [AW-1:0] wr_idx;
   logic          do_alloc;
   logic          do_retrig;
   logic          do_clear;
   logic          do_steal;
   logic          do_drop;
   logic          scan_hit;

   logic          slot_en   [VOICES];
   logic [3:0]    slot_ch   [VOICES];
   logic [6:0]    slot_note [VOICES];
   logic [6:0]    slot_vel  [VOICES];

`ifdef VOICE_STEAL_EN
   logic [AW-1:0] steal_ptr;
`endif

   function automatic logic [AW:0] cnt_inc(input logic [AW:0] c);
      return (c == CNT_MAX) ? c : c + 1'b1;
   endfunction

   function automatic logic [AW:0] cnt_dec(input logic [AW:0] c);
      return (c == '0) ? c : c - 1'b1;
   endfunction

   assign scan_hit = slot_en[idx] && (slot_ch[idx] == ev_ch) && (slot_note[idx] == ev_note);

   // Commit decision: retrigger beats allocation, allocation beats steal/drop
   always_comb begin
      do_alloc  = 1'b0;
      do_retrig = 1'b0;
      do_clear  = 1'b0;
      do_steal  = 1'b0;
      do_drop   = 1'b0;
      wr_idx    = free_idx;
      if (state == S_COMMIT) begin
         if (ev_on) begin
            if (match_f) begin
               do_retrig = 1'b1;
            end else if (free_f) begin
               do_alloc = 1'b1;
            end else begin
`ifdef VOICE_STEAL_EN
               do_steal = 1'b1;
               wr_idx   = steal_ptr;
`else
               do_drop  = 1'b1;
`endif
            end
         end else if (match_f) begin
            do_clear = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_res) begin
         state        <= S_IDLE;
         o_ev_ready   <= 1'b1;
         idx          <= '0;
         match_f      <= 1'b0;
         free_f       <= 1'b0;
         o_active_cnt <= '0;
         o_drop       <= 1'b0;
`ifdef VOICE_STEAL_EN
         steal_ptr    <= '0;
`endif
      end else begin
         o_drop <= 1'b0;
         case (state)
            S_IDLE: begin
               if (i_ev_valid) begin
                  ev_on      <= i_ev_on && (i_ev_vel != 7'd0);
                  ev_ch      <= i_ev_ch;
                  ev_note    <= i_ev_note;
                  ev_vel     <= i_ev_vel;
                  match_f    <= 1'b0;
                  free_f     <= 1'b0;
                  idx        <= '0;
                  o_ev_ready <= 1'b0;
                  state      <= S_SCAN;
               end
            end
            S_SCAN: begin
               if (!match_f && scan_hit) begin
                  match_f   <= 1'b1;
                  match_idx <= idx;
               end
               if (!free_f && !slot_en[idx]) begin
                  free_f   <= 1'b1;
                  free_idx <= idx;
               end
               idx <= idx + 1'b1;
               if (idx == LAST) state <= S_COMMIT;
            end
            S_COMMIT: begin
               if (do_alloc) begin
                  o_active_cnt <= cnt_inc(o_active_cnt);
               end else if (do_clear) begin
                  o_active_cnt <= cnt_dec(o_active_cnt);
               end
               o_drop <= do_drop;
`ifdef VOICE_STEAL_EN
               if (do_steal) steal_ptr <= steal_ptr + 1'b1;
`endif
               o_ev_ready <= 1'b1;
               state      <= S_IDLE;
            end
            default: begin
               o_ev_ready <= 1'b1;
               state      <= S_IDLE;
            end
         endcase
      end
   end

   // Table: only the enable bits are reset; note data survives for the scanners
   always_ff @(posedge i_clk) begin
      if (i_res) begin
         for (int i = 0; i < VOICES; i++) slot_en[i] <= 1'b0;
      end else if (do_alloc || do_steal) begin
         slot_en[wr_idx] <= 1'b1;
      end else if (do_clear) begin
         slot_en[match_idx] <= 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_res) begin
         if (do_retrig) slot_vel[match_idx] <= ev_vel;
         if (do_alloc || do_steal) begin
            slot_ch[wr_idx]   <= ev_ch;
            slot_note[wr_idx] <= ev_note;
            slot_vel[wr_idx]  <= ev_vel;
         end
      end
   end

   // Read stage: sees the table before any write on the same edge
   always_ff @(posedge i_clk) begin
      if (i_res) begin
         o_rddata <= 16'h0000;
      end else begin
         o_rddata <= {slot_en[i_rdaddr], slot_note[i_rdaddr], 1'b0, slot_vel[i_rdaddr]};
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_res) begin
         assert (!(do_alloc && o_active_cnt == CNT_MAX));
         assert (!(do_clear && o_active_cnt == '0));
      end
   end

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: directed steps plus random events against a slot-table model.
module tb_voice_allocator;

   localparam int VOICES = 64;
   localparam int AW     = 6;

   logic          clk = 1'b0;
   logic          i_res;
   logic          i_ev_valid;
   logic          o_ev_ready;
   logic          i_ev_on;
   logic [3:0]    i_ev_ch;
   logic [6:0]    i_ev_note;
   logic [6:0]    i_ev_vel;
   logic [AW-1:0] i_rdaddr;
   logic [15:0]   o_rddata;
   logic [AW:0]   o_active_cnt;
   logic          o_drop;

   voice_allocator #(.VOICES(VOICES), .AW(AW)) dut (
      .i_clk(clk), .i_res(i_res), .i_ev_valid(i_ev_valid), .o_ev_ready(o_ev_ready),
      .i_ev_on(i_ev_on), .i_ev_ch(i_ev_ch), .i_ev_note(i_ev_note), .i_ev_vel(i_ev_vel),
      .i_rdaddr(i_rdaddr), .o_rddata(o_rddata), .o_active_cnt(o_active_cnt), .o_drop(o_drop)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic       m_en    [VOICES];
   logic       m_known [VOICES];
   logic [3:0] m_ch    [VOICES];
   logic [6:0] m_note  [VOICES];
   logic [6:0] m_vel   [VOICES];
   int         m_cnt;
   int         m_steal;

   int          lat;
   logic        drop0, drop1;
   logic [15:0] rd0, rd1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < VOICES; i++) m_en[i] = 1'b0;
      m_cnt   = 0;
      m_steal = 0;
   endtask

   function automatic logic [15:0] exp_word(input int a);
      return {m_en[a], m_note[a], 1'b0, m_vel[a]};
   endfunction

   // Reference behaviour from the allocation rules; returns the expected drop pulse
   function automatic logic model_apply(input logic on, input logic [3:0] ch,
                                        input logic [6:0] note, input logic [6:0] vel);
      int mi = -1;
      int fi = -1;
      int t;
      for (int i = 0; i < VOICES; i++) begin
         if (mi < 0 && m_en[i] && m_ch[i] == ch && m_note[i] == note) mi = i;
         if (fi < 0 && !m_en[i]) fi = i;
      end
      if (on && vel != 0) begin
         if (mi >= 0) begin
            m_vel[mi] = vel;
         end else begin
            if (fi >= 0) begin
               t = fi;
               m_cnt++;
            end else begin
`ifdef VOICE_STEAL_EN
               t = m_steal;
               m_steal = (m_steal + 1) % VOICES;
`else
               return 1'b1;
`endif
            end
            m_en[t] = 1'b1; m_known[t] = 1'b1;
            m_ch[t] = ch; m_note[t] = note; m_vel[t] = vel;
         end
      end else if (mi >= 0) begin
         m_en[mi] = 1'b0;
         m_cnt--;
      end
      return 1'b0;
   endfunction

   // Entered and left at #1 after a rising edge; inputs are scrambled during the scan
   task automatic send(input logic on, input logic [3:0] ch, input logic [6:0] note, input logic [6:0] vel);
      chk("ready_before_event", o_ev_ready, 1'b1);
      i_ev_valid = 1'b1; i_ev_on = on; i_ev_ch = ch; i_ev_note = note; i_ev_vel = vel;
      @(posedge clk); #1;
      i_ev_valid = 1'b0;
      i_ev_on = 1'($urandom); i_ev_ch = 4'($urandom); i_ev_note = 7'($urandom); i_ev_vel = 7'($urandom);
      lat = 1;
      while (!o_ev_ready && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      drop0 = o_drop; rd0 = o_rddata;
      @(posedge clk); #1;
      drop1 = o_drop; rd1 = o_rddata;
   endtask

   task automatic ev(input logic on, input logic [3:0] ch, input logic [6:0] note, input logic [6:0] vel);
      logic exp_drop;
      send(on, ch, note, vel);
      exp_drop = model_apply(on, ch, note, vel);
      chk("latency", lat, VOICES + 2);
      chk("drop_after_commit", drop0, exp_drop);
      chk("drop_one_cycle", drop1, 1'b0);
      chk("active_cnt", o_active_cnt, m_cnt);
   endtask

   task automatic rd(input int a, output logic [15:0] w);
      i_rdaddr = AW'(a);
      @(posedge clk); #1;
      w = o_rddata;
   endtask

   task automatic check_slot(input int a);
      logic [15:0] w;
      rd(a, w);
      if (m_known[a]) chk($sformatf("slot%0d", a), w, exp_word(a));
      else chk($sformatf("slot%0d_en", a), w[15], m_en[a]);
   endtask

   task automatic sweep();
      for (int a = 0; a < VOICES; a++) check_slot(a);
   endtask

   task automatic random_events(input int n, input int nch, input int nnote);
      logic       on;
      logic [3:0] ch;
      logic [6:0] note, vel;
      for (int k = 0; k < n; k++) begin
         on   = 1'($urandom_range(0, 1));
         ch   = 4'($urandom_range(0, nch - 1));
         note = 7'(60 + $urandom_range(0, nnote - 1));
         vel  = ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
         ev(on, ch, note, vel);
         check_slot($urandom_range(0, 7));
      end
   endtask

   initial begin
      logic [15:0] w, old_w, new_w;
      logic [6:0]  nv;

      for (int i = 0; i < VOICES; i++) m_known[i] = 1'b0;
      model_reset();
      i_res = 1'b1; i_ev_valid = 1'b0; i_ev_on = 1'b0; i_ev_ch = '0;
      i_ev_note = '0; i_ev_vel = '0; i_rdaddr = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_rddata", o_rddata, 16'h0000);
      chk("reset_cnt", o_active_cnt, 0);
      chk("reset_drop", o_drop, 1'b0);
      chk("reset_ready", o_ev_ready, 1'b1);
      i_res = 1'b0;
      @(posedge clk); #1;
      chk("ready_after_reset", o_ev_ready, 1'b1);

      ev(1'b1, 4'd0, 7'd60, 7'd100);
      rd(0, w);
      chk("tp_on_slot0", w, 16'hBC64);
      chk("tp_on_cnt", o_active_cnt, 1);
      ev(1'b1, 4'd0, 7'd60, 7'd20);
      rd(0, w);
      chk("tp_retrig_slot0", w, 16'hBC14);
      chk("tp_retrig_cnt", o_active_cnt, 1);
      check_slot(1);
      ev(1'b1, 4'd0, 7'd60, 7'd0);
      rd(0, w);
      chk("tp_off_slot0", w, 16'h3C14);
      chk("tp_off_cnt", o_active_cnt, 0);
      ev(1'b0, 4'd0, 7'd60, 7'd55);
      rd(0, w);
      chk("tp_off_again_slot0", w, 16'h3C14);
      chk("tp_off_again_cnt", o_active_cnt, 0);

      random_events(60, 2, 4);

      i_res = 1'b1;
      @(posedge clk); #1;
      i_res = 1'b0;
      model_reset();
      chk("reset2_cnt", o_active_cnt, 0);
      sweep();

      for (int i = 0; i < VOICES; i++)
         ev(1'b1, 4'(i), 7'(70 + i / 16), 7'($urandom_range(1, 127)));
      chk("full_cnt", o_active_cnt, VOICES);
      sweep();

      // Retrigger slot 3 while it is being read back continuously
      old_w = exp_word(3);
      nv = (m_vel[3] == 7'd99) ? 7'd98 : 7'd99;
      i_rdaddr = AW'(3);
      ev(1'b1, 4'd3, 7'd70, nv);
      new_w = exp_word(3);
      chk("rd_during_commit_old", rd0, old_w);
      chk("rd_after_commit_new", rd1, new_w);
      chk("rd_new_vel", rd1[6:0], nv);

      ev(1'b1, 4'd0, 7'd10, 7'd55);
`ifdef VOICE_STEAL_EN
      rd(0, w);
      chk("steal_slot0", w, {1'b1, 7'd10, 1'b0, 7'd55});
      ev(1'b1, 4'd0, 7'd11, 7'd66);
      rd(1, w);
      chk("steal_slot1", w, {1'b1, 7'd11, 1'b0, 7'd66});
`else
      chk("overflow_drop", drop0, 1'b1);
`endif
      chk("overflow_cnt", o_active_cnt, VOICES);
      sweep();

      // Abort a note-on with reset at scan index 30
      i_ev_valid = 1'b1; i_ev_on = 1'b1; i_ev_ch = 4'd5; i_ev_note = 7'd50; i_ev_vel = 7'd33;
      @(posedge clk); #1;
      i_ev_valid = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      chk("busy_mid_scan", o_ev_ready, 1'b0);
      i_res = 1'b1;
      @(posedge clk); #1;
      i_res = 1'b0;
      model_reset();
      chk("abort_ready", o_ev_ready, 1'b1);
      chk("abort_cnt", o_active_cnt, 0);
      chk("abort_rddata", o_rddata, 16'h0000);
      chk("abort_drop", o_drop, 1'b0);
      @(posedge clk); #1;
      chk("abort_ready_hold", o_ev_ready, 1'b1);
      sweep();

      random_events(60, 4, 2);
      sweep();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
